// File: rtl/sram_req_adapter_pkg.sv
// Shared memory-message header for the SRAM request adapter.
// Holds request-type encodings, stage-1 state bundle and helpers.
package sram_req_adapter_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    logic      in_flight;
    mem_type_e kind;
  } s1_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_req_adapter_if.sv
// Request/response handshake bundle for sram_req_adapter.
// master = requester side, slave = adapter side.
interface sram_req_adapter_if #(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 256
);
  localparam int c_addr_nbits  = $clog2(p_num_entries);
  localparam int c_data_nbytes = (p_data_nbits + 7) / 8;

  logic                     req_val;
  logic                     req_rdy;
  logic                     req_type;
  logic [c_addr_nbits-1:0]  req_addr;
  logic [p_data_nbits-1:0]  req_data;
  logic [c_data_nbytes-1:0] req_byte_en;

  logic                     resp_val;
  logic                     resp_rdy;
  logic                     resp_type;
  logic [p_data_nbits-1:0]  resp_data;

  modport master (
    output req_val, req_type, req_addr,
    output req_data, req_byte_en, resp_rdy,
    input  req_rdy, resp_val, resp_type, resp_data
  );

  modport slave (
    input  req_val, req_type, req_addr,
    input  req_data, req_byte_en, resp_rdy,
    output req_rdy, resp_val, resp_type, resp_data
  );

endinterface

// File: rtl/sram_req_adapter_resp_queue.sv
// Non-bypass FIFO with occupancy output for adapter responses.
// Ports: clk, reset, enq_val/enq_data, deq_val/deq_rdy/deq_data, occ.
module sram_req_adapter_resp_queue
  import sram_req_adapter_pkg::*;
#(
  parameter  int p_depth     = 2,
  parameter  int p_width     = 33,
  localparam int c_ptr_nbits = clog2_min1(p_depth),
  localparam int c_cnt_nbits = $clog2(p_depth + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_width-1:0]     enq_data,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_width-1:0]     deq_data,
  output logic [c_cnt_nbits-1:0] occ
);

  localparam logic [c_ptr_nbits-1:0] c_last =
    c_ptr_nbits'(p_depth - 1);
  localparam logic [c_cnt_nbits-1:0] c_full =
    c_cnt_nbits'(p_depth);

  logic [p_width-1:0]     mem [p_depth];
  logic [c_ptr_nbits-1:0] wr_ptr;
  logic [c_ptr_nbits-1:0] rd_ptr;
  logic                   deq;

  function automatic logic [c_ptr_nbits-1:0] nxt(
    input logic [c_ptr_nbits-1:0] p
  );
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  assign deq_val  = (occ != '0);
  assign deq      = deq_val && deq_rdy;
  assign deq_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (enq_val) wr_ptr <= nxt(wr_ptr);
      if (deq)     rd_ptr <= nxt(rd_ptr);
      case ({enq_val, deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_val) mem[wr_ptr] <= enq_data;
  end

  // The upstream credit check guarantees room for every enqueue.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(enq_val && !deq && occ == c_full)
  );

endmodule

// File: rtl/sram_req_adapter.sv
// Val/rdy request adapter in front of a 1rw synchronous SRAM.
// Ports: clk, reset, bus (slave), sram read/write port signals.
module sram_req_adapter
  import sram_req_adapter_pkg::*;
#(
  parameter  int p_data_nbits   = 32,
  parameter  int p_num_entries  = 256,
  parameter  int p_resp_entries = 2,
  localparam int c_addr_nbits   = $clog2(p_num_entries),
  localparam int c_data_nbytes  = (p_data_nbits + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  sram_req_adapter_if.slave        bus,
  output logic                     sram_read_en,
  output logic [c_addr_nbits-1:0]  sram_read_addr,
  input  logic [p_data_nbits-1:0]  sram_read_data,
  output logic                     sram_write_en,
  output logic [c_data_nbytes-1:0] sram_write_byte_en,
  output logic [c_addr_nbits-1:0]  sram_write_addr,
  output logic [p_data_nbits-1:0]  sram_write_data
);

  localparam int c_cnt_nbits = $clog2(p_resp_entries + 1);
  localparam int c_cr_nbits  = c_cnt_nbits + 1;
  localparam logic [c_cr_nbits-1:0] c_credits =
    c_cr_nbits'(p_resp_entries);
  localparam logic [c_addr_nbits:0] c_addr_lim =
    (c_addr_nbits + 1)'(p_num_entries);

  s1_state_t                s1;
  logic                     fire;
  logic                     deq;
  logic                     q_val;
  logic [p_data_nbits:0]    q_enq_data;
  logic [p_data_nbits:0]    q_deq_data;
  logic [c_cnt_nbits-1:0]   occ;
  logic [c_cr_nbits-1:0]    used;

  assign fire = bus.req_val && bus.req_rdy;

  // Buffer contents are discarded by reset; hide them meanwhile.
  assign bus.resp_val  = q_val && !reset;
  assign bus.resp_type = q_deq_data[p_data_nbits];
  assign bus.resp_data = q_deq_data[p_data_nbits-1:0];
  assign deq           = bus.resp_val && bus.resp_rdy;

  // An in-flight request already owns a slot; a dequeue this
  // cycle frees one, which keeps full throughput at depth 2.
  assign used = c_cr_nbits'(occ)
              + c_cr_nbits'(s1.in_flight)
              - c_cr_nbits'(deq);
  assign bus.req_rdy = !reset && (used < c_credits);

  always_comb begin
    sram_read_en       = fire && (bus.req_type == MEM_READ);
    sram_write_en      = fire && (bus.req_type == MEM_WRITE);
    sram_read_addr     = bus.req_addr;
    sram_write_addr    = bus.req_addr;
    sram_write_data    = bus.req_data;
    sram_write_byte_en = bus.req_byte_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '{in_flight: 1'b0, kind: MEM_READ};
    end else begin
      s1.in_flight <= fire;
      if (fire) s1.kind <= mem_type_e'(bus.req_type);
    end
  end

  always_comb begin
    q_enq_data = '0;
    q_enq_data[p_data_nbits] = (s1.kind == MEM_WRITE);
    if (s1.kind == MEM_READ)
      q_enq_data[p_data_nbits-1:0] = sram_read_data;
  end

  sram_req_adapter_resp_queue #(
    .p_depth (p_resp_entries),
    .p_width (p_data_nbits + 1)
  ) u_resp_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (s1.in_flight),
    .enq_data (q_enq_data),
    .deq_val  (q_val),
    .deq_rdy  (bus.resp_rdy),
    .deq_data (q_deq_data),
    .occ      (occ)
  );

  a_req_val_known: assert property (
    @(posedge clk) disable iff (reset)
    !$isunknown(bus.req_val)
  );

  a_resp_rdy_known: assert property (
    @(posedge clk) disable iff (reset)
    !$isunknown(bus.resp_rdy)
  );

  a_addr_range: assert property (
    @(posedge clk) disable iff (reset)
    fire |-> ({1'b0, bus.req_addr} < c_addr_lim)
  );

  a_byte_en_known: assert property (
    @(posedge clk) disable iff (reset)
    fire |-> !$isunknown(bus.req_byte_en)
  );

  a_one_port: assert property (
    @(posedge clk) disable iff (reset)
    !(sram_read_en && sram_write_en)
  );

endmodule

// File: doc/sram_req_adapter.md
SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

Interface
REQ-001: Parameter p_data_nbits, default 32, SRAM word width in bits.
REQ-002: Parameter p_num_entries, default 256, SRAM depth in words; c_addr_nbits = $clog2(p_num_entries).
REQ-003: Parameter p_resp_entries, default 2, response buffer depth (minimum 2); c_data_nbytes = (p_data_nbits+7)/8.
REQ-004: clk  input  1  sole clock; all state updates on rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: req_val / req_rdy  input / output  1 / 1  request handshake; fire = req_val && req_rdy.
REQ-007: req_type  input  1  0 = read, 1 = write.
REQ-008: req_addr / req_data / req_byte_en  input  c_addr_nbits / p_data_nbits / c_data_nbytes  word address, write data, byte enables.
REQ-009: resp_val / resp_rdy  output / input  1 / 1  response handshake.
REQ-010: resp_type / resp_data  output  1 / p_data_nbits  echoed type, read data (0 for writes).
REQ-011: sram_read_en, sram_read_addr  output  1, c_addr_nbits  synchronous 1rw SRAM read port.
REQ-012: sram_read_data  input  p_data_nbits  SRAM registered read data, valid the cycle after sram_read_en.
REQ-013: sram_write_en, sram_write_byte_en, sram_write_addr, sram_write_data  output  1, c_data_nbytes, c_addr_nbits, p_data_nbits  SRAM write port.

Function
REQ-014: Two-stage pipeline: stage 0 issues the fired request to the SRAM in the same cycle; stage 1 (next cycle) enqueues the response into the response buffer.
REQ-015: On a read fire: sram_read_en=1, sram_read_addr=req_addr, sram_write_en=0, in that cycle only.
REQ-016: On a write fire: sram_write_en=1, address/data/byte_en passed through, sram_read_en=0, in that cycle only.
REQ-017: sram_read_en and sram_write_en SHALL be 0 in every cycle without a fire and never both 1.
REQ-018: Stage 1 holds in_flight (1 bit) and type; when in_flight=1 a response {type, read ? sram_read_data : 0} is enqueued unconditionally.
REQ-019: Minimum latency: request fire in cycle t -> resp_val=1 in cycle t+2.
REQ-020: Credit rule: req_rdy = (occ + in_flight - (resp_val && resp_rdy)) < p_resp_entries, where occ is buffer occupancy; enqueue never overflows.
REQ-021: Full throughput: with resp_rdy held 1, one request accepted and one response delivered per cycle in steady state.
REQ-022: Responses returned strictly in request order; resp_val/resp_type/resp_data stable while resp_val=1 and resp_rdy=0.
REQ-023: Simultaneous enqueue and dequeue in one cycle leaves occ unchanged; enqueue into an empty buffer is not bypassed (resp_val rises the following cycle).
REQ-024: Buffer pointers wrap modulo p_resp_entries.

Reset
REQ-025: While reset=1: req_rdy=0, resp_val=0, sram_read_en=0, sram_write_en=0, in_flight cleared, occ=0, pointers=0.
REQ-026: Reset asserted mid-operation discards in-flight and buffered responses; first cycle after reset req_rdy=1.
REQ-027: resp_data/resp_type and SRAM address/data outputs are don't-care when their valid/enable is 0.

Structure
REQ-028: Request-type encodings (READ=0, WRITE=1) live in the shared memory-message header, not locally.
REQ-029: Response buffer is one sub-module, sram_req_adapter_resp_queue (normal, non-bypass FIFO with occupancy output), parameterised by depth and width.
REQ-030: Assertions (outside reset): req_val, resp_rdy not X; req_addr < p_num_entries and req_byte_en not X on fire.

Verification
REQ-031: Write addr 0x05 data 0xDEADBEEF byte_en 0xF at t -> sram_write_en=1 at t; resp_val, resp_type=1, resp_data=0 at t+2.
REQ-032: Read addr 0x05 after above -> sram_read_en=1 addr 0x05; response type 0 data 0xDEADBEEF at t+2.
REQ-033: Byte-enable write 0x000000AA byte_en 0x1 to addr 0x05 then read -> 0xDEADBEAA.
REQ-034: 16 back-to-back reads, resp_rdy=1 -> 16 accepts in 16 consecutive cycles, responses in order, no bubbles.
REQ-035: resp_rdy=0 for 10 cycles under continuous req_val -> exactly p_resp_entries accepted, req_rdy=0 thereafter, responses intact when resp_rdy returns 1.
REQ-036: Reset asserted with in_flight=1 and occ=1 -> resp_val=0 next cycle, no stale response emitted after reset.
